fcpu_rob: RTL
=============

Name: fcpu_rob

Overview:
- Reorder buffer for the fcpu out-of-order core.
- Receives in-order allocations from dispatch and out-of-order results from the common data bus (CDB).
- Emits an in-order commit stream tagged with commit_type_t toward the register file, memory and branch units.
- Raises a one-cycle flush when a mispredicted branch retires.

Parameters:
- N_ROB_W, 4: log2 of entry count (16 entries).
- DATA_W, 32: result data width.
- REG_ADDR_W, 5: destination register address width.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- alloc_valid  in  1  dispatch requests an entry.
- alloc_ready  out  1  entry available.
- alloc_type  in  3  commit_type_t of the instruction.
- alloc_dst_reg  in  REG_ADDR_W  destination register.
- alloc_tag  out  N_ROB_W  index the entry will receive (current tail).
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  N_ROB_W  ROB index of the result.
- cdb_data  in  DATA_W  result value.
- cdb_mispredict  in  1  branch result was mispredicted (meaningful for commit_branch only).
- commit_valid  out  1  head entry retirable.
- commit_ready  in  1  consumer accepts the commit.
- commit_type  out  3  commit_type_t of the head entry.
- commit_dst_reg  out  REG_ADDR_W  head destination register.
- commit_data  out  DATA_W  head result.
- commit_tag  out  N_ROB_W  head index.
- flush  out  1  one-cycle pipeline flush pulse.
- count  out  N_ROB_W+1  occupied entries.

Behaviour:
- Reset (rstn=0 at a clk edge):
  - head=tail=0, all entry valid/ready/mispredict bits cleared, state=RUN.
  - Outputs: flush=0, count=0, commit_valid=0, alloc_ready=1, alloc_tag=0.
  - Reset mid-operation discards all entries; the next cycle behaves as after power-up.
- Storage and pointers:
  - Circular buffer of 2**N_ROB_W entries.
  - Each entry holds valid, ready, mispredict, type, dst_reg and data.
  - head/tail are N_ROB_W+1 bits; the MSB is a wrap bit.
  - empty: head==tail. full: low bits equal and MSBs differ.
  - count = tail-head, modulo 2**(N_ROB_W+1).
- State machine:
  - RUN to FLUSH on a commit handshake of a head entry with type==commit_branch and mispredict=1.
  - FLUSH to RUN unconditionally after one cycle.
- RUN state:
  - alloc_ready = !full. No bypass: a simultaneous commit does not free space in the same cycle.
  - Allocate on alloc_valid&&alloc_ready: write entry[tail] with valid=1, ready=0, then tail++.
  - alloc_tag = tail low bits, registered-state only.
  - CDB: if cdb_valid and entry[cdb_tag].valid, set ready=1, data=cdb_data and mispredict=cdb_mispredict. A CDB write to an invalid entry is ignored.
  - A CDB write to an already-ready entry overwrites it; this is a legal no-op case for the bench.
  - commit_valid = entry[head].valid && entry[head].ready. Commit outputs are driven from registered state only, so no combinational path from cdb_* or alloc_* to commit_*.
  - A result becomes committable the cycle after its CDB write.
  - Commit on commit_valid&&commit_ready: clear entry[head].valid, then head++.
  - commit_* outputs hold stable while commit_valid=1 and commit_ready=0.
  - Allocate and commit may occur in the same cycle; count is unchanged.
- Mispredict commit edge:
  - All entries are invalidated and head=tail=0.
  - Any allocation accepted in that same cycle is dropped; dispatch discards it on flush.
  - flush=1 for exactly the next cycle.
- FLUSH state:
  - alloc_ready=0, commit_valid=0, CDB input ignored.
  - Returns to RUN the next cycle with count=0.
- Wrap-around: pointer low bits roll from 2**N_ROB_W-1 to 0 and the wrap bit toggles; full/empty stay correct across any number of wraps.
- Latency:
  - alloc to visible in count: 1 cycle.
  - CDB to commit_valid: 1 cycle.
  - Commit handshake to next head presented: 1 cycle.

Test Plan:
- Fill: 16 back-to-back allocs with cdb idle.
  - alloc_tag goes 0..15, count=16, alloc_ready=0 on cycle 17, commit_valid=0 throughout.
- Out-of-order completion: alloc tags 0,1,2; CDB writes tag2=0x33, tag0=0x11, tag1=0x22; commit_ready=1.
  - Commits in order 0x11, 0x22, 0x33 with tags 0,1,2; count returns to 0.
- Backpressure: head ready, commit_ready=0 for 5 cycles.
  - commit_valid=1 with data/tag stable; no head advance; count unchanged.
- Mispredict: alloc int(tag0), branch(tag1), int(tag2). CDB tag1 with mispredict=1, tag0, tag2.
  - tag0 commits, then tag1 commits; flush=1 for one cycle; tag2 never commits; count=0; next alloc_tag=0.
- Wrap and simultaneous events: run 40 alloc/complete/commit cycles with alloc+commit overlapping.
  - Commit order matches alloc order; full/empty correct across wraps; no lost or duplicated tags.
- Reset mid-operation: 8 entries live, 3 ready; pull rstn low for 1 cycle.
  - count=0, commit_valid=0, flush=0, alloc_tag=0; a subsequent stale CDB tag3 write is ignored.

Source files
------------

// File: rtl/fcpu_rob.sv
// Reorder buffer for the fcpu out-of-order core: in-order allocate, out-of-order
// CDB completion, in-order commit, and a one-cycle flush when a mispredicted branch retires.
module fcpu_rob #(
   parameter int N_ROB_W    = 4,
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  alloc_valid,
   output logic                  alloc_ready,
   input  logic [2:0]            alloc_type,
   input  logic [REG_ADDR_W-1:0] alloc_dst_reg,
   output logic [N_ROB_W-1:0]    alloc_tag,
   input  logic                  cdb_valid,
   input  logic [N_ROB_W-1:0]    cdb_tag,
   input  logic [DATA_W-1:0]     cdb_data,
   input  logic                  cdb_mispredict,
   output logic                  commit_valid,
   input  logic                  commit_ready,
   output logic [2:0]            commit_type,
   output logic [REG_ADDR_W-1:0] commit_dst_reg,
   output logic [DATA_W-1:0]     commit_data,
   output logic [N_ROB_W-1:0]    commit_tag,
   output logic                  flush,
   output logic [N_ROB_W:0]      count
);

   localparam int              DEPTH         = 2 ** N_ROB_W;
   localparam logic [2:0]      COMMIT_BRANCH = 3'd3;
   localparam logic [0:0]      ST_RUN        = 1'b0;
   localparam logic [0:0]      ST_FLUSH      = 1'b1;
   localparam logic [N_ROB_W:0] PTR_ONE      = {{N_ROB_W{1'b0}}, 1'b1};

   logic [0:0]            state_r;
   logic [N_ROB_W:0]      head_r;
   logic [N_ROB_W:0]      tail_r;
   logic [DEPTH-1:0]      valid_r;
   logic [DEPTH-1:0]      ready_r;
   logic [DEPTH-1:0]      mispredict_r;
   logic [2:0]            type_r [DEPTH];
   logic [REG_ADDR_W-1:0] dst_r  [DEPTH];
   logic [DATA_W-1:0]     data_r [DEPTH];

   logic [N_ROB_W-1:0] head_idx_s;
   logic [N_ROB_W-1:0] tail_idx_s;
   logic               run_s;
   logic               full_s;
   logic               alloc_fire_s;
   logic               commit_fire_s;
   logic               cdb_hit_s;
   logic               mp_commit_s;

   assign head_idx_s = head_r[N_ROB_W-1:0];
   assign tail_idx_s = tail_r[N_ROB_W-1:0];
   assign run_s      = (state_r == ST_RUN);
   // Full when the slot indices coincide but the wrap bits disagree.
   assign full_s     = (head_idx_s == tail_idx_s) && (head_r[N_ROB_W] != tail_r[N_ROB_W]);

   assign alloc_ready    = run_s && !full_s;
   assign alloc_tag      = tail_idx_s;
   assign commit_valid   = run_s && valid_r[head_idx_s] && ready_r[head_idx_s];
   assign commit_type    = type_r[head_idx_s];
   assign commit_dst_reg = dst_r[head_idx_s];
   assign commit_data    = data_r[head_idx_s];
   assign commit_tag     = head_idx_s;
   assign flush          = (state_r == ST_FLUSH);
   assign count          = tail_r - head_r;

   assign alloc_fire_s  = alloc_valid && alloc_ready;
   assign commit_fire_s = commit_valid && commit_ready;
   assign cdb_hit_s     = run_s && cdb_valid && valid_r[cdb_tag];
   assign mp_commit_s   = commit_fire_s && (commit_type == COMMIT_BRANCH) && mispredict_r[head_idx_s];

   // Pointer, state and per-entry flag update
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_r      <= ST_RUN;
         head_r       <= '0;
         tail_r       <= '0;
         valid_r      <= '0;
         ready_r      <= '0;
         mispredict_r <= '0;
      end else if (state_r == ST_FLUSH) begin
         state_r <= ST_RUN;
      end else if (mp_commit_s) begin
         // Mispredict retire squashes everything, including a same-cycle allocation.
         state_r      <= ST_FLUSH;
         head_r       <= '0;
         tail_r       <= '0;
         valid_r      <= '0;
         ready_r      <= '0;
         mispredict_r <= '0;
      end else begin
         if (cdb_hit_s) begin
            ready_r[cdb_tag]      <= 1'b1;
            mispredict_r[cdb_tag] <= cdb_mispredict;
         end
         if (alloc_fire_s) begin
            valid_r[tail_idx_s]      <= 1'b1;
            ready_r[tail_idx_s]      <= 1'b0;
            mispredict_r[tail_idx_s] <= 1'b0;
            tail_r                   <= tail_r + PTR_ONE;
         end
         if (commit_fire_s) begin
            valid_r[head_idx_s] <= 1'b0;
            head_r              <= head_r + PTR_ONE;
         end
      end
   end

   // Entry payload capture: type/destination at allocation, result at CDB hit
   always_ff @(posedge clk) begin
      if (alloc_fire_s) begin
         type_r[tail_idx_s] <= alloc_type;
         dst_r[tail_idx_s]  <= alloc_dst_reg;
      end
      if (cdb_hit_s) begin
         data_r[cdb_tag] <= cdb_data;
      end
   end

endmodule
